// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU with a valid/ready handshake on both sides. Logic ops,
// ADD, SUB, PASS and unknown opcodes finish in one cycle; shifts move one
// bit per cycle; MUL is an iterative shift-add over a 2*WIDTH-bit product.
// The result and flags are registered and held until the next result.
//
// Optional feature macro: SEQ_ALU_MUL_EN
//   defined     -> opcode 10 is an unsigned WIDTH-cycle multiply, out_hi live
//   not defined -> opcode 10 is an unknown opcode, out_hi tied to 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   block can accept (IDLE and out of reset)
//   A, B       operands (low SHW bits of B are the shift amount)
//   op         4-bit opcode
//   out_valid  result registers valid
//   out_ready  consumer takes the result
//   out        result (low half for MUL)
//   out_hi     upper half of MUL product, 0 otherwise
//   zero, negative, carry, overflow  result flags (from out only)
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;

    localparam logic [SHW-1:0] SH_ZERO = SHW'(0);
    localparam logic [SHW-1:0] SH_ONE  = SHW'(1);

`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0]     OP_MUL  = 4'd10;
    localparam logic [SHW-1:0] SH_LAST = SHW'(WIDTH - 1);
`endif

    // Flag helper: result is all zeros.
    function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       op_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             neg_r;
    logic             carry_r;
    logic             ovf_r;

    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             accept_s;
    logic             finish_s;
    logic             load_s;

    logic [WIDTH-1:0] sc_out_s;
    logic             sc_carry_s;
    logic             sc_ovf_s;
    logic             sc_multi_s;
    logic [WIDTH-1:0] sc_work_s;
    logic [SHW-1:0]   sc_cnt_s;

    logic [WIDTH-1:0] busy_out_s;
    logic             busy_carry_s;

    logic [WIDTH-1:0] res_out_s;
    logic             res_carry_s;
    logic             res_ovf_s;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] ma_r;
    logic [WIDTH-1:0]   mb_r;
    logic [WIDTH-1:0]   out_hi_r;
    logic [2*WIDTH-1:0] mul_sum_s;
    logic [WIDTH-1:0]   busy_hi_s;
    logic [WIDTH-1:0]   res_hi_s;
`endif

    assign in_ready  = (state_r == ST_IDLE) && rst_n;
    assign out_valid = (state_r == ST_DONE);
    assign out       = out_r;
    assign zero      = zero_r;
    assign negative  = neg_r;
    assign carry     = carry_r;
    assign overflow  = ovf_r;

    assign shamt_s  = B[SHW-1:0];
    assign sum_s    = {1'b0, A} + {1'b0, B};
    assign diff_s   = {1'b0, A} - {1'b0, B};
    assign accept_s = in_valid && in_ready;
    // Last iteration: the BUSY edge that produces the final value.
    assign finish_s = (state_r == ST_BUSY) && (cnt_r == SH_ONE);
    assign load_s   = (accept_s && !sc_multi_s) || finish_s;

    // Decode of the accepted operation: single-cycle result or first iteration.
    always_comb begin
        sc_out_s   = {WIDTH{1'b0}};
        sc_carry_s = 1'b0;
        sc_ovf_s   = 1'b0;
        sc_multi_s = 1'b0;
        sc_work_s  = {WIDTH{1'b0}};
        sc_cnt_s   = SH_ZERO;
        case (op)
            OP_OR:   sc_out_s = A | B;
            OP_AND:  sc_out_s = A & B;
            OP_XOR:  sc_out_s = A ^ B;
            OP_NOT:  sc_out_s = ~A;
            OP_PASS: sc_out_s = B;
            OP_ADD: begin
                sc_out_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
                sc_ovf_s   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out_s   = diff_s[WIDTH-1:0];
                sc_carry_s = diff_s[WIDTH];  // borrow: A < B unsigned
                sc_ovf_s   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SHL: begin
                // First bit is shifted on the accepting edge.
                sc_work_s = {A[WIDTH-2:0], 1'b0};
                sc_cnt_s  = shamt_s - SH_ONE;
                if (shamt_s == SH_ZERO) begin
                    sc_out_s = A;
                end else if (shamt_s == SH_ONE) begin
                    sc_out_s   = {A[WIDTH-2:0], 1'b0};
                    sc_carry_s = A[WIDTH-1];
                end else begin
                    sc_multi_s = 1'b1;
                end
            end
            OP_SHR: begin
                sc_work_s = {1'b0, A[WIDTH-1:1]};
                sc_cnt_s  = shamt_s - SH_ONE;
                if (shamt_s == SH_ZERO) begin
                    sc_out_s = A;
                end else if (shamt_s == SH_ONE) begin
                    sc_out_s   = {1'b0, A[WIDTH-1:1]};
                    sc_carry_s = A[0];
                end else begin
                    sc_multi_s = 1'b1;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                // Iteration 0 happens on the accepting edge, WIDTH-1 remain.
                sc_multi_s = 1'b1;
                sc_cnt_s   = SH_LAST;
            end
`endif
            default: sc_out_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign mul_sum_s = acc_r + (mb_r[0] ? ma_r : {(2*WIDTH){1'b0}});
`endif

    // One BUSY iteration: next shift value or next partial product.
    always_comb begin
        busy_out_s   = {1'b0, work_r[WIDTH-1:1]};
        busy_carry_s = work_r[0];
`ifdef SEQ_ALU_MUL_EN
        busy_hi_s    = {WIDTH{1'b0}};
`endif
        case (op_r)
            OP_SHL: begin
                busy_out_s   = {work_r[WIDTH-2:0], 1'b0};
                busy_carry_s = work_r[WIDTH-1];
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                busy_out_s   = mul_sum_s[WIDTH-1:0];
                busy_hi_s    = mul_sum_s[2*WIDTH-1:WIDTH];
                busy_carry_s = !f_is_zero(mul_sum_s[2*WIDTH-1:WIDTH]);
            end
`endif
            default: begin
                busy_out_s   = {1'b0, work_r[WIDTH-1:1]};
                busy_carry_s = work_r[0];
            end
        endcase
    end

    // Select what gets written into the result registers.
    always_comb begin
        if (finish_s) begin
            res_out_s   = busy_out_s;
            res_carry_s = busy_carry_s;
            res_ovf_s   = 1'b0;
        end else begin
            res_out_s   = sc_out_s;
            res_carry_s = sc_carry_s;
            res_ovf_s   = sc_ovf_s;
        end
    end

    // Control FSM, iteration counter and shift working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            cnt_r   <= SH_ZERO;
            work_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r <= op;
                        if (sc_multi_s) begin
                            state_r <= ST_BUSY;
                            cnt_r   <= sc_cnt_s;
                            work_r  <= sc_work_s;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == SH_ONE) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r  <= cnt_r - SH_ONE;
                        work_r <= busy_out_s;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Result and flag registers: written only on the edge that raises out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= {WIDTH{1'b0}};
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (load_s) begin
            out_r   <= res_out_s;
            zero_r  <= f_is_zero(res_out_s);
            neg_r   <= res_out_s[WIDTH-1];
            carry_r <= res_carry_s;
            ovf_r   <= res_ovf_s;
        end else begin
            out_r   <= out_r;
            zero_r  <= zero_r;
            neg_r   <= neg_r;
            carry_r <= carry_r;
            ovf_r   <= ovf_r;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    assign res_hi_s = finish_s ? busy_hi_s : {WIDTH{1'b0}};
    assign out_hi   = out_hi_r;

    // Shift-add multiplier datapath: accumulator, shifted multiplicand, multiplier bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {(2*WIDTH){1'b0}};
            ma_r  <= {(2*WIDTH){1'b0}};
            mb_r  <= {WIDTH{1'b0}};
        end else if (accept_s && (op == OP_MUL)) begin
            acc_r <= B[0] ? {{WIDTH{1'b0}}, A} : {(2*WIDTH){1'b0}};
            ma_r  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
            mb_r  <= {1'b0, B[WIDTH-1:1]};
        end else if ((state_r == ST_BUSY) && (op_r == OP_MUL)) begin
            acc_r <= mul_sum_s;
            ma_r  <= {ma_r[2*WIDTH-2:0], 1'b0};
            mb_r  <= {1'b0, mb_r[WIDTH-1:1]};
        end else begin
            acc_r <= acc_r;
            ma_r  <= ma_r;
            mb_r  <= mb_r;
        end
    end

    // Upper product half, updated together with the other result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hi_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            out_hi_r <= res_hi_s;
        end else begin
            out_hi_r <= out_hi_r;
        end
    end
`else
    assign out_hi = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (WIDTH=8), with hand-written
// sequences for backpressure and reset-abort behaviour.
module tb_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       zero;
    logic       negative;
    logic       carry;
    logic       overflow;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] out;
        logic [7:0] hi;
        logic [3:0] flags;  // {zero, negative, carry, overflow}
        int         lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                           input logic [7:0] res, input logic [7:0] hi,
                           input logic [3:0] flags, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.out = res; v.hi = hi; v.flags = flags; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Offer one operation, then count edges from the accepting edge to out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                         output int lat);
        @(negedge clk);
        A = a; B = b; op = o; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the output handshake; in_ready must be back right after.
    task automatic take(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_valid_dropped"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        string nm;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A  = 8'd0;
        B  = 8'd0;
        op = 4'd0;

        //        a      b      op     out    hi     {z,n,c,v} lat
        add_vec(8'd250, 8'd7,  4'd5,  8'h01, 8'h00, 4'b0010, 1);  // ADD wrap, carry
        add_vec(8'd3,   8'd5,  4'd8,  8'hFE, 8'h00, 4'b0110, 1);  // SUB borrow
        add_vec(8'h7F,  8'h01, 4'd5,  8'h80, 8'h00, 4'b0101, 1);  // ADD signed ovf
        add_vec(8'hFF,  8'h01, 4'd5,  8'h00, 8'h00, 4'b1010, 1);  // ADD to zero
        add_vec(8'h80,  8'h01, 4'd8,  8'h7F, 8'h00, 4'b0001, 1);  // SUB signed ovf
        add_vec(8'd5,   8'd5,  4'd8,  8'h00, 8'h00, 4'b1000, 1);  // SUB equal
        add_vec(8'h81,  8'd3,  4'd6,  8'h08, 8'h00, 4'b0000, 3);  // SHL n=3
        add_vec(8'h01,  8'd1,  4'd9,  8'h00, 8'h00, 4'b1010, 1);  // SHR n=1
        add_vec(8'hFF,  8'd2,  4'd6,  8'hFC, 8'h00, 4'b0110, 2);  // SHL n=2
        add_vec(8'h83,  8'd2,  4'd9,  8'h20, 8'h00, 4'b0010, 2);  // SHR n=2
        add_vec(8'h01,  8'd7,  4'd6,  8'h80, 8'h00, 4'b0100, 7);  // SHL max n
        add_vec(8'h81,  8'h08, 4'd6,  8'h81, 8'h00, 4'b0100, 1);  // SHL n=0 (upper B ignored)
        add_vec(8'h08,  8'h02, 4'd1,  8'h0A, 8'h00, 4'b0000, 1);  // OR
        add_vec(8'hF0,  8'hFF, 4'd3,  8'h0F, 8'h00, 4'b0000, 1);  // XOR
        add_vec(8'h12,  8'h80, 4'd7,  8'h80, 8'h00, 4'b0100, 1);  // PASS
        add_vec(8'hFF,  8'hFF, 4'd0,  8'h00, 8'h00, 4'b1000, 1);  // unknown 0
        add_vec(8'hFF,  8'hFF, 4'd15, 8'h00, 8'h00, 4'b1000, 1);  // unknown 15
`ifdef SEQ_ALU_MUL_EN
        add_vec(8'd15,  8'd17, 4'd10, 8'hFF, 8'h00, 4'b0100, 8);  // MUL 255
        add_vec(8'd16,  8'd16, 4'd10, 8'h00, 8'h01, 4'b1010, 8);  // MUL 256
        add_vec(8'hFF,  8'hFF, 4'd10, 8'h01, 8'hFE, 4'b0010, 8);  // MUL max
`else
        add_vec(8'd15,  8'd17, 4'd10, 8'h00, 8'h00, 4'b1000, 1);  // op 10 unknown
`endif
        add_vec(8'h55,  8'h00, 4'd4,  8'hAA, 8'h00, 4'b0100, 1);  // NOT (nonzero last)

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_out_hi", {24'd0, out_hi}, 32'd0);
        chk("rst_flags", {28'd0, zero, negative, carry, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            nm = $sformatf("v%0d", i);
            chk({nm, "_lat"}, lat, vecs[i].lat);
            chk({nm, "_out"}, {24'd0, out}, {24'd0, vecs[i].out});
            chk({nm, "_hi"}, {24'd0, out_hi}, {24'd0, vecs[i].hi});
            chk({nm, "_flags"}, {28'd0, zero, negative, carry, overflow}, {28'd0, vecs[i].flags});
            chk({nm, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
            take(nm);
            chk({nm, "_held"}, {24'd0, out}, {24'd0, vecs[i].out});
        end

        // Reset in the middle of a multi-cycle operation.
        @(negedge clk);
`ifdef SEQ_ALU_MUL_EN
        A = 8'd15; B = 8'd17; op = 4'd10;
`else
        A = 8'hFF; B = 8'd7; op = 4'd6;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("abort_busy_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", {24'd0, out}, 32'd0);
        chk("abort_out_hi", {24'd0, out_hi}, 32'd0);
        chk("abort_flags", {28'd0, zero, negative, carry, overflow}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        do_op(8'h08, 8'h02, 4'd1, lat);
        chk("after_abort_lat", lat, 1);
        chk("after_abort_out", {24'd0, out}, 32'h0A);
        take("after_abort");

        // Backpressure: result held, extra in_valid ignored.
        do_op(8'h02, 8'h05, 4'd2, lat);
        chk("bp_lat", lat, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                A = 8'h08; B = 8'h02; op = 4'd1; in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            nm = $sformatf("bp_c%0d", k);
            chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, "_out"}, {24'd0, out}, 32'd0);
            chk({nm, "_zero"}, {31'd0, zero}, 32'd1);
            chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        take("bp");
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("bp_second_ignored", seen, 0);
        chk("bp_out_held", {24'd0, out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. It takes one operation at a time through a valid/ready input handshake and computes it in one or more cycles. Shifts run one bit per cycle and multiply uses iterative shift-add. The result and a full flag set (zero, negative, carry, overflow) are held in registers behind a valid/ready output handshake. It sits between the register-file read stage and write-back in the datapath.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥4
- SHW, $clog2(WIDTH), derived; shift-amount width (low SHW bits of B)
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low (synchronous deassert expected upstream)
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept; equals (state==IDLE) and rst_n high
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B / shift amount
- op  input  4  opcode
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result, low half for MUL
- out_hi  output  WIDTH  upper half of MUL product, 0 for other ops
- zero  output  1  out == 0
- negative  output  1  out[WIDTH-1]
- carry  output  1  see Operation
- overflow  output  1  signed overflow, ADD/SUB only

## Operation
- Opcodes: 1 OR, 2 AND, 3 XOR, 4 NOT(A), 5 ADD, 6 SHL, 7 PASS(B), 8 SUB(A−B), 9 SHR (logical), 10 MUL (unsigned); all others are unknown.
- Unknown opcode: out=0, out_hi=0, zero=1, other flags 0, single-cycle.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready and latch A, B, op.
  - BUSY: iterating.
  - DONE: out_valid=1; DONE→IDLE on out_ready.
  - IDLE→DONE for single-cycle ops. IDLE→BUSY for SHL/SHR with amount>1, and for MUL.
- Shifts: amount n = B[SHW-1:0]. One bit is shifted per cycle, with 0 shifted in. carry = last bit shifted out (0 if n=0).
- ADD: carry = carry-out. SUB: carry = borrow (A<B unsigned). overflow = two's-complement signed overflow.
- MUL: WIDTH-cycle shift-add over an internal 2·WIDTH-bit product. carry = (out_hi != 0).
- Logic ops and PASS: carry=0, overflow=0.
- zero and negative are computed from out only, never from out_hi.
- Inputs are ignored outside IDLE; no queuing.
- All arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Latency from the accepting edge to out_valid high:
  - 1 cycle for logic ops, ADD, SUB, PASS, unknown opcodes, and shifts with n≤1
  - n cycles for shifts with n≥2
  - WIDTH cycles for MUL
- out, out_hi and flags update only on the edge that raises out_valid. They are stable while out_valid=1 and are held after the handoff until the next result.
- Handoff occurs on the edge where out_valid&&out_ready. in_ready rises the following cycle, so there is at most one new accept every latency+1 cycles.
- out_ready high before out_valid has no effect.
- Reset values: state IDLE, out_valid=0, in_ready=0 while rst_n low, and out, out_hi, zero, negative, carry, overflow all 0.
- Reset mid-BUSY or mid-DONE aborts immediately. The result is discarded and no partial out_valid appears.

## Configuration
- SEQ_ALU_MUL_EN defined: opcode 10 is MUL as above, including the product register and iteration counter.
- Not defined: the multiplier logic is absent, opcode 10 decodes as an unknown opcode, and out_hi is tied to 0.

## Test plan
- ADD A=250, B=7 (WIDTH=8) → out=1, carry=1, overflow=0, zero=0, out_valid one cycle after accept.
- SUB A=3, B=5 → out=0xFE, carry=1, negative=1. Then ADD A=0x7F, B=1 → out=0x80, overflow=1, negative=1.
- SHL A=0x81, B=3 → out=0x08, carry=0, out_valid 3 cycles after accept, in_ready low throughout. SHR A=0x01, B=1 → out=0, zero=1, carry=1.
- MUL with SEQ_ALU_MUL_EN defined:
  - 15×17 → out=0xFF, out_hi=0, carry=0, 8-cycle latency
  - 16×16 → out=0, out_hi=1, zero=1, carry=1
  - Without the macro, op 10 → out=0, zero=1, 1-cycle.
- Backpressure: AND 0x02&0x05 done, out_ready held low 5 cycles → out=0, zero=1 held stable. A second in_valid is ignored. in_ready rises the cycle after out_ready.
- rst_n pulsed low 4 cycles into a MUL → all outputs 0 immediately, no out_valid. A subsequent OR 0x08|0x02 yields out=0x0A after 1 cycle.
